strhw_msg_feeder: RTL

- Upstream feeder for the Streebog hash core. It sits directly in front of the core's trigger/block/block_size inputs.
- Accepts the message as a stream of 64-bit words over a valid/ready handshake and assembles them into 512-bit blocks.
- Applies Streebog padding (0x01 then zeros) to the final partial block and computes block_size.
- Triggers the core once per block and holds off new input until the core reports the block is done.

---
 rtl/strhw_msg_feeder_if.sv | 25 ++
 rtl/strhw_msg_feeder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/strhw_msg_feeder_if.sv
// Message-word stream in, Streebog core block/trigger out, plus core completion back.
// The slave modport is the feeder itself; the master modport is the surrounding logic.
interface strhw_msg_feeder_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [63:0]  in_data_i;
    logic         in_last_i;
    logic [3:0]   in_bytes_i;
    logic         core_trg_o;
    logic         core_done_i;
    logic [511:0] block_o;
    logic [6:0]   block_size_o;
    logic         final_o;
    logic         busy_o;

    modport slave (
        input  in_valid_i, in_data_i, in_last_i, in_bytes_i, core_done_i,
        output in_ready_o, core_trg_o, block_o, block_size_o, final_o, busy_o
    );

    modport master (
        output in_valid_i, in_data_i, in_last_i, in_bytes_i, core_done_i,
        input  in_ready_o, core_trg_o, block_o, block_size_o, final_o, busy_o
    );
endinterface

// File: rtl/strhw_msg_feeder.sv
// Packs 64-bit words into padded 512-bit Streebog blocks; trigger one cycle after the closing word.
// Input is stalled (in_ready_o=0) from block issue until the core's done pulse.
module strhw_msg_feeder #(
    parameter int WORDS = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    strhw_msg_feeder_if.slave  bus
);
    localparam int BLK_BITS = WORDS * 64;

    typedef enum logic [1:0] {FILL, ISSUE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [6:0]          bytes_q, bytes_d;
    logic [BLK_BITS-1:0] acc_q, acc_d;
    logic [BLK_BITS-1:0] out_q, out_d;
    logic [6:0]          size_q, size_d;
    logic                final_q, final_d;
    logic                pend_q, pend_d;

    logic                hs;
    logic [6:0]          add;
    logic [6:0]          sum;
    logic [BLK_BITS-1:0] asm_blk;
    logic [BLK_BITS-1:0] padded;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bytes_d = bytes_q;
        acc_d   = acc_q;
        out_d   = out_q;
        size_d  = size_q;
        final_d = final_q;
        pend_d  = pend_q;

        hs = bus.in_valid_i && (state_q == FILL);

        if (!bus.in_last_i || bus.in_bytes_i > 4'd8) add = 7'd8;
        else                                         add = {3'b000, bus.in_bytes_i};
        sum = bytes_q + add;

        asm_blk = acc_q;
        asm_blk[{cnt_q[2:0], 6'b000000} +: 64] = bus.in_data_i;

        // Bytes at or beyond the running total are replaced by the 0x01/0x00 pad,
        // which also scrubs stale slots left over from the previous block.
        padded = '0;
        for (int b = 0; b < 64; b++) begin
            if (7'(b) < sum)       padded[8*b +: 8] = asm_blk[8*b +: 8];
            else if (7'(b) == sum) padded[8*b +: 8] = 8'h01;
            else                   padded[8*b +: 8] = 8'h00;
        end

        case (state_q)
            FILL: begin
                if (hs) begin
                    acc_d   = asm_blk;
                    cnt_d   = cnt_q + 4'd1;
                    bytes_d = sum;
                    if (bus.in_last_i || cnt_q == 4'd7) begin
                        state_d = ISSUE;
                        out_d   = padded;
                        size_d  = sum;
                        final_d = bus.in_last_i && (sum != 7'd64);
                        pend_d  = bus.in_last_i && (sum == 7'd64);
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.core_done_i) begin
                    if (pend_q) begin
                        // Message ended exactly on a block boundary: follow with a pad-only block.
                        out_d        = '0;
                        out_d[7:0]   = 8'h01;
                        size_d       = 7'd0;
                        final_d      = 1'b1;
                        pend_d       = 1'b0;
                        state_d      = ISSUE;
                    end else begin
                        cnt_d   = 4'd0;
                        bytes_d = 7'd0;
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= FILL;
            cnt_q   <= 4'd0;
            bytes_q <= 7'd0;
            acc_q   <= '0;
            out_q   <= '0;
            size_q  <= 7'd0;
            final_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bytes_q <= bytes_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            size_q  <= size_d;
            final_q <= final_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.in_ready_o   = (state_q == FILL);
    assign bus.core_trg_o   = (state_q == ISSUE);
    assign bus.block_o      = out_q;
    assign bus.block_size_o = size_q;
    assign bus.final_o      = final_q;
    assign bus.busy_o       = (state_q != FILL) || (cnt_q != 4'd0);
endmodule
